// File: rtl/env_pkg.sv
// env_pkg: shared types and width/constant helpers for the envelope follower.
//
// Contents:
//   env_state_t  - controller state encoding {IDLE, RECT, UPD, SQRT, OUT}
//   acc_width()  - accumulator width: DATA_W + ALPHA_W
//   max_int()    - most positive signed value for a given sample width
//   min_int()    - bit pattern of the most negative signed value
//   acc_clamp()  - largest legal accumulator value {MAX_INT, all-ones fraction}
//
// Every helper takes the widths as arguments, so one package serves every
// parameterisation of env_follower_mc.
package env_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECT = 3'd1,
    UPD  = 3'd2,
    SQRT = 3'd3,
    OUT  = 3'd4
  } env_state_t;

  function automatic int acc_width(input int data_w, input int alpha_w);
    return data_w + alpha_w;
  endfunction

  function automatic logic [63:0] max_int(input int data_w);
    return (64'd1 << (data_w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] min_int(input int data_w);
    return 64'd1 << (data_w - 1);
  endfunction

  // The sign position of the integer part is never set, so the envelope read
  // back from the accumulator can never exceed MAX_INT.
  function automatic logic [63:0] acc_clamp(input int data_w, input int alpha_w);
    return (64'd1 << (data_w - 1 + alpha_w)) - 64'd1;
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// isqrt_seq: sequential restoring integer square root.
//
// Produces root = floor(sqrt(din)). One result bit is resolved per clock.
// The first bit is resolved on the edge that sees start, so the final root
// is in place, with done pulsed high, W-1 edges after that.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        load din and begin (ignored while not needed by caller)
//   din[2W-1:0]  radicand
//   busy         iterations still outstanding
//   done         one-cycle pulse: root is final
//   root[W-1:0]  square root result
module isqrt_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] din,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   root
);
  localparam int REM_W = W + 2;
  localparam int CNT_W = $clog2(W + 1);

  logic [REM_W-1:0] rem_q;
  logic [2*W-1:0]   op_q;
  logic [CNT_W-1:0] cnt_q;

  logic [REM_W-1:0] rem_src;
  logic [2*W-1:0]   op_src;
  logic [W-1:0]     root_src;
  logic [REM_W+1:0] rem_sh;
  logic [REM_W+1:0] trial;
  logic [REM_W-1:0] rem_step;
  logic [W-1:0]     root_step;

  // One restoring step. On start the step works directly on din so the
  // loading edge is also the first iteration.
  always_comb begin
    rem_src  = start ? '0 : rem_q;
    op_src   = start ? din : op_q;
    root_src = start ? '0 : root;
    rem_sh   = {rem_src, op_src[2*W-1 -: 2]};
    trial    = {2'b00, root_src, 2'b01};
    if (rem_sh >= trial) begin
      rem_step  = REM_W'(rem_sh - trial);
      root_step = {root_src[W-2:0], 1'b1};
    end else begin
      rem_step  = rem_sh[REM_W-1:0];
      root_step = {root_src[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      op_q  <= '0;
      cnt_q <= '0;
      root  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= rem_step;
        op_q  <= {op_src[2*W-3:0], 2'b00};
        root  <= root_step;
        cnt_q <= CNT_W'(W - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_step;
        op_q  <= {op_src[2*W-3:0], 2'b00};
        root  <= root_step;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/env_follower_mc.sv
// env_follower_mc: time-multiplexed multi-channel envelope follower.
//
// Each accepted sample is rectified, optionally squared (RMS mode), and fed
// into a per-channel first-order leaky integrator with separate attack and
// release coefficients. One result is produced per accepted sample on a
// valid/ready output carrying the channel tag.
//
// Build option:
//   ENV_RMS_EN  when defined, builds the squarer, the SQRT state and the
//               isqrt_seq instance; mode=1 selects RMS. When undefined, mode
//               is ignored and every sample takes the mean-absolute path.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   s_valid/s_ready      input handshake (ready only while idle)
//   s_data, s_ch         signed sample and its channel index
//   alpha_att/alpha_rel  Q0.ALPHA_W attack / release coefficients
//   mode                 0 = mean-absolute, 1 = RMS
//   bypass               output |sample| instead of the envelope
//   m_valid/m_ready      output handshake
//   m_data, m_ch         unsigned result and its channel tag
//
// State table:
//   IDLE | waiting for a sample, s_ready high
//   RECT | rectify / square the captured sample, drop bad channel index
//   UPD  | leaky-integrator update and accumulator write-back
//   SQRT | sequential square root of the mean-square result
//   OUT  | result presented, waiting for m_ready
module env_follower_mc
  import env_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ALPHA_W = 16,
  parameter int NCH     = 4,
  parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic [CH_W-1:0]    s_ch,
  input  logic [ALPHA_W-1:0] alpha_att,
  input  logic [ALPHA_W-1:0] alpha_rel,
  input  logic               mode,
  input  logic               bypass,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic [CH_W-1:0]    m_ch
);
  localparam int ACC_W = acc_width(DATA_W, ALPHA_W);
  // acc + prod spans roughly [-2^ACC_W, 2^(ACC_W+1)); three extra bits hold
  // the sign and the headroom before clamping.
  localparam int NXT_W = ACC_W + 3;
  localparam int CH_N  = 1 << CH_W;

  localparam logic [DATA_W-1:0] MAX_INT = DATA_W'(max_int(DATA_W));
  localparam logic [DATA_W-1:0] MIN_INT = DATA_W'(min_int(DATA_W));
  localparam logic [ACC_W-1:0]  ACC_MAX = ACC_W'(acc_clamp(DATA_W, ALPHA_W));
  // One bit per encodable channel index; set for the channels that exist.
  localparam logic [CH_N-1:0]   CH_OK   = CH_N'({NCH{1'b1}});

  env_state_t         state;
  logic [DATA_W-1:0]  cap_data;
  logic [CH_W-1:0]    cap_ch;
  logic [ALPHA_W-1:0] cap_att;
  logic [ALPHA_W-1:0] cap_rel;
  logic               cap_bypass;
  logic [DATA_W-1:0]  abs_r;
  logic [DATA_W-1:0]  tgt_r;
  logic [ACC_W-1:0]   acc [NCH];

  logic [DATA_W-1:0]  abs_c;
  logic [DATA_W-1:0]  tgt_c;
  logic               mode_eff;

  assign s_ready = (state == IDLE);

  // Rectifier. MIN_INT has no positive twin, so it saturates to MAX_INT.
  always_comb begin
    abs_c = cap_data;
    if (cap_data == MIN_INT) begin
      abs_c = MAX_INT;
    end else if (cap_data[DATA_W-1]) begin
      abs_c = -cap_data;
    end
  end

`ifdef ENV_RMS_EN
  logic                cap_mode;
  logic [2*DATA_W-1:0] sq_full;
  logic                sq_start;
  logic                sq_done;
  logic                unused_sq_busy;
  logic [DATA_W-1:0]   sq_root;

  // abs <= MAX_INT, so (abs*abs) >> (DATA_W-1) always fits in DATA_W-1 bits.
  assign sq_full  = (2*DATA_W)'(abs_c) * (2*DATA_W)'(abs_c);
  assign tgt_c    = cap_mode ? DATA_W'(sq_full >> (DATA_W - 1)) : abs_c;
  assign mode_eff = cap_mode;
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign tgt_c       = abs_c;
  assign mode_eff    = 1'b0;
`endif

  logic [ACC_W-1:0]        acc_cur;
  logic [ACC_W-1:0]        acc_nxt;
  logic [DATA_W-1:0]       env_c;
  logic [DATA_W-1:0]       res_c;
  logic [ALPHA_W-1:0]      alpha_c;
  logic signed [DATA_W:0]  diff_c;
  logic signed [ACC_W+1:0] prod_c;
  logic signed [NXT_W-1:0] sum_c;

  // Leaky integrator: acc += (target - env) * alpha, with env the integer
  // part of acc. The product is exact; only the final sum is clamped.
  always_comb begin
    acc_cur = acc[cap_ch];
    env_c   = acc_cur[ACC_W-1:ALPHA_W];
    alpha_c = (tgt_r > env_c) ? cap_att : cap_rel;
    diff_c  = $signed({1'b0, tgt_r}) - $signed({1'b0, env_c});
    prod_c  = diff_c * $signed({1'b0, alpha_c});
    sum_c   = $signed({3'b000, acc_cur}) + NXT_W'(prod_c);
    if (sum_c < 0) begin
      acc_nxt = '0;
    end else if (sum_c > $signed({3'b000, ACC_MAX})) begin
      acc_nxt = ACC_MAX;
    end else begin
      acc_nxt = sum_c[ACC_W-1:0];
    end
    res_c = acc_nxt[ACC_W-1:ALPHA_W];
  end

`ifdef ENV_RMS_EN
  // The root is started straight from the combinational update result so
  // the loading edge doubles as the first root iteration.
  assign sq_start = (state == UPD) && cap_mode;

  isqrt_seq #(
    .W (DATA_W)
  ) u_isqrt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (sq_start),
    .din   ({1'b0, res_c, {(DATA_W-1){1'b0}}}),
    .busy  (unused_sq_busy),
    .done  (sq_done),
    .root  (sq_root)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_data   <= '0;
      cap_ch     <= '0;
      cap_att    <= '0;
      cap_rel    <= '0;
      cap_bypass <= 1'b0;
`ifdef ENV_RMS_EN
      cap_mode   <= 1'b0;
`endif
      abs_r      <= '0;
      tgt_r      <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_ch       <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            cap_data   <= s_data;
            cap_ch     <= s_ch;
            cap_att    <= alpha_att;
            cap_rel    <= alpha_rel;
            cap_bypass <= bypass;
`ifdef ENV_RMS_EN
            cap_mode   <= mode;
`endif
            state      <= RECT;
          end
        end
        RECT: begin
          abs_r <= abs_c;
          tgt_r <= tgt_c;
          // A sample for a channel that does not exist is consumed silently.
          state <= CH_OK[cap_ch] ? UPD : IDLE;
        end
        UPD: begin
          acc[cap_ch] <= acc_nxt;
          if (mode_eff) begin
            state <= SQRT;
          end else begin
            m_valid <= 1'b1;
            m_data  <= cap_bypass ? abs_r : res_c;
            m_ch    <= cap_ch;
            state   <= OUT;
          end
        end
`ifdef ENV_RMS_EN
        SQRT: begin
          // Bypass still walks the root so RMS latency does not depend on it.
          if (sq_done) begin
            m_valid <= 1'b1;
            m_data  <= cap_bypass ? abs_r : sq_root;
            m_ch    <= cap_ch;
            state   <= OUT;
          end
        end
`endif
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
